dcsk_symbol_sequencer: RTL and testbench

//  Sequences one DCSK symbol per message bit for a spreading factor of type sf_t.

---
 rtl/dcsk_symbol_sequencer_pkg.sv | 34 +++
 rtl/dcsk_chip_counter.sv | 40 ++++
 rtl/dcsk_symbol_sequencer.sv | 154 +++++++++++++++
 tb/tb_dcsk_symbol_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcsk_symbol_sequencer_pkg.sv
// ============================================================================
// Module : dcsk_symbol_sequencer_pkg
// Brief  : Spreading-factor types, chip-count helpers and sequencer state enum.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dcsk_symbol_sequencer_pkg;

    typedef enum logic [1:0] {
        SF2  = 2'd0,
        SF4  = 2'd1,
        SF8  = 2'd2,
        SF16 = 2'd3
    } sf_t;

    localparam int MAX_HALF_LEN = 16;
    localparam int CHIP_IDX_W   = 4;
    localparam int HALF_LEN_W   = CHIP_IDX_W + 1;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_REF  = 2'd1,
        SEQ_DATA = 2'd2
    } dcsk_seq_state_t;

    // Chips per half-symbol: 2 << sf, i.e. 2, 4, 8 or 16.
    function automatic logic [HALF_LEN_W-1:0] sf_half_len(input sf_t sf);
        return HALF_LEN_W'(2) << sf;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcsk_chip_counter.sv
// ============================================================================
// Module : dcsk_chip_counter
// Brief  : Chip index counter shared by the REF and DATA halves of a symbol.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcsk_chip_counter
    import dcsk_symbol_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_inc,
    input  logic [HALF_LEN_W-1:0] i_limit,
    output logic [CHIP_IDX_W-1:0] o_cnt,
    output logic                  o_last
);

    logic [CHIP_IDX_W-1:0] r_cnt;
    logic [HALF_LEN_W-1:0] w_limit_m1;

    assign w_limit_m1 = i_limit - HALF_LEN_W'(1);
    assign o_last     = (HALF_LEN_W'(r_cnt) == w_limit_m1);
    assign o_cnt      = r_cnt;

    // Wrapping at the last chip lets a half hand over straight to the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_last ? '0 : r_cnt + CHIP_IDX_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcsk_symbol_sequencer.sv
// ============================================================================
// Module : dcsk_symbol_sequencer
// Brief  : Per-bit DCSK symbol control: REF half (send/store chaos), DATA half
//          (replay stored chips with bit polarity).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcsk_symbol_sequencer
    import dcsk_symbol_sequencer_pkg::*;
#(
    parameter int SYM_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  sf_t                   sf_i,
    input  logic                  bit_valid_i,
    input  logic                  bit_i,
    output logic                  bit_ready_o,
    output logic                  chip_valid_o,
    input  logic                  chip_ready_i,
    output logic                  phase_o,
    output logic [CHIP_IDX_W-1:0] chip_idx_o,
    output logic                  chaos_adv_o,
    output logic                  ref_wr_en_o,
    output logic                  ref_rd_en_o,
    output logic                  polarity_o,
    output logic                  sym_start_o,
    output logic                  sym_end_o,
    output logic                  busy_o,
    output logic [SYM_CNT_W-1:0]  sym_cnt_o
);

    dcsk_seq_state_t       r_state;
    dcsk_seq_state_t       w_state_nxt;
    logic                  r_bit;
    sf_t                   r_sf;
    logic [SYM_CNT_W-1:0]  r_sym_cnt;

    logic [HALF_LEN_W-1:0] w_half_len;
    logic [CHIP_IDX_W-1:0] w_cnt;
    logic                  w_last;
    logic                  w_acc;
    logic                  w_bit_acc;
    logic                  w_bit_ready;
    logic                  w_sym_end;

    assign w_half_len = sf_half_len(r_sf);
    assign w_acc      = chip_valid_o & chip_ready_i;
    assign w_bit_acc  = bit_valid_i & w_bit_ready;

    dcsk_chip_counter u_chip_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_bit_acc),
        .i_inc   (w_acc),
        .i_limit (w_half_len),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_IDLE: begin
                if (w_bit_acc) begin
                    w_state_nxt = SEQ_REF;
                end
            end
            SEQ_REF: begin
                if (w_acc && w_last) begin
                    w_state_nxt = SEQ_DATA;
                end
            end
            SEQ_DATA: begin
                if (w_acc && w_last) begin
                    w_state_nxt = w_bit_acc ? SEQ_REF : SEQ_IDLE;
                end
            end
            default: w_state_nxt = SEQ_IDLE;
        endcase
    end

    // bit_ready is held low while reset is applied so every output reads 0.
    always_comb begin
        w_bit_ready  = 1'b0;
        chip_valid_o = 1'b0;
        phase_o      = 1'b0;
        chaos_adv_o  = 1'b0;
        ref_wr_en_o  = 1'b0;
        ref_rd_en_o  = 1'b0;
        polarity_o   = 1'b0;
        sym_start_o  = 1'b0;
        w_sym_end    = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                w_bit_ready = en_i & ~rst;
            end
            SEQ_REF: begin
                chip_valid_o = 1'b1;
                chaos_adv_o  = w_acc;
                ref_wr_en_o  = w_acc;
                sym_start_o  = w_acc & (w_cnt == '0);
            end
            SEQ_DATA: begin
                chip_valid_o = 1'b1;
                phase_o      = 1'b1;
                polarity_o   = r_bit;
                ref_rd_en_o  = w_acc;
                w_sym_end    = w_acc & w_last;
                w_bit_ready  = en_i & ~rst & w_acc & w_last;
            end
            default: begin
                w_bit_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit <= 1'b0;
            r_sf  <= SF2;
        end else if (w_bit_acc) begin
            r_bit <= bit_i;
            r_sf  <= sf_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym_cnt <= '0;
        end else if (w_sym_end) begin
            r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1);
        end
    end

    assign bit_ready_o = w_bit_ready;
    assign sym_end_o   = w_sym_end;
    assign chip_idx_o  = w_cnt;
    assign busy_o      = (r_state != SEQ_IDLE);
    assign sym_cnt_o   = r_sym_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dcsk_symbol_sequencer.sv
// ============================================================================
// Module : tb_dcsk_symbol_sequencer
// Brief  : Directed self-checking bench for dcsk_symbol_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dcsk_symbol_sequencer;
    import dcsk_symbol_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst, en, bv, bi, cr;
    sf_t  sf;

    logic       a_rdy, a_v, a_ph, a_adv, a_wr, a_rd, a_pol, a_st, a_end, a_busy;
    logic [3:0] a_idx;
    logic [15:0] a_cnt;
    logic       b_rdy, b_v, b_ph, b_adv, b_wr, b_rd, b_pol, b_st, b_end, b_busy;
    logic [3:0] b_idx;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;
    int rdy_pulses;

    always #5 clk = ~clk;

    dcsk_symbol_sequencer #(.SYM_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en_i(en), .sf_i(sf), .bit_valid_i(bv), .bit_i(bi),
        .bit_ready_o(a_rdy), .chip_valid_o(a_v), .chip_ready_i(cr), .phase_o(a_ph),
        .chip_idx_o(a_idx), .chaos_adv_o(a_adv), .ref_wr_en_o(a_wr), .ref_rd_en_o(a_rd),
        .polarity_o(a_pol), .sym_start_o(a_st), .sym_end_o(a_end), .busy_o(a_busy),
        .sym_cnt_o(a_cnt)
    );

    dcsk_symbol_sequencer #(.SYM_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en_i(en), .sf_i(sf), .bit_valid_i(bv), .bit_i(bi),
        .bit_ready_o(b_rdy), .chip_valid_o(b_v), .chip_ready_i(cr), .phase_o(b_ph),
        .chip_idx_o(b_idx), .chaos_adv_o(b_adv), .ref_wr_en_o(b_wr), .ref_rd_en_o(b_rd),
        .polarity_o(b_pol), .sym_start_o(b_st), .sym_end_o(b_end), .busy_o(b_busy),
        .sym_cnt_o(b_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Control vector order: valid, phase, idx, adv, wr, rd, pol, start, end, ready, busy
    task automatic exp_ctl(input string tag, input logic v, input logic ph,
                           input logic [3:0] idx, input logic adv, input logic rd,
                           input logic pol, input logic st, input logic en_, input logic rdy);
        logic [13:0] exp_v, obs_a, obs_b;
        exp_v = {v, ph, idx, adv, adv, rd, pol, st, en_, rdy, v};
        obs_a = {a_v, a_ph, a_idx, a_adv, a_wr, a_rd, a_pol, a_st, a_end, a_rdy, a_busy};
        obs_b = {b_v, b_ph, b_idx, b_adv, b_wr, b_rd, b_pol, b_st, b_end, b_rdy, b_busy};
        checks++;
        assert (obs_a === exp_v) else begin
            errors++;
            $error("FAIL %s ctl16 observed=%b expected=%b", tag, obs_a, exp_v);
        end
        checks++;
        assert (obs_b === exp_v) else begin
            errors++;
            $error("FAIL %s ctl2 observed=%b expected=%b", tag, obs_b, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] e16, input logic [1:0] e2);
        checks++;
        assert (a_cnt === e16) else begin
            errors++;
            $error("FAIL %s sym_cnt16 observed=%0d expected=%0d", tag, a_cnt, e16);
        end
        checks++;
        assert (b_cnt === e2) else begin
            errors++;
            $error("FAIL %s sym_cnt2 observed=%0d expected=%0d", tag, b_cnt, e2);
        end
    endtask

    initial begin
        logic ph;
        logic [3:0] idx;

        // Reset: everything 0 even with en high
        rst = 1'b1; en = 1'b1; sf = SF2; bv = 1'b0; bi = 1'b0; cr = 1'b1;
        #12;
        exp_ctl("reset", 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        chk_cnt("reset", 16'd0, 2'd0);
        rst = 1'b0;
        #1;
        exp_ctl("idle_after_reset", 0, 0, 4'd0, 0, 0, 0, 0, 0, 1);

        // Test 1: SF2, bit 1
        sf = SF2; bi = 1'b1; bv = 1'b1;
        #1;
        cyc();
        bv = 1'b0;
        #1; exp_ctl("t1_ref0", 1, 0, 4'd0, 1, 0, 0, 1, 0, 0); cyc();
        #1; exp_ctl("t1_ref1", 1, 0, 4'd1, 1, 0, 0, 0, 0, 0); cyc();
        #1; exp_ctl("t1_dat0", 1, 1, 4'd0, 0, 1, 1, 0, 0, 0); cyc();
        #1; exp_ctl("t1_dat1", 1, 1, 4'd1, 0, 1, 1, 0, 1, 1);
        chk_cnt("t1_before_end", 16'd0, 2'd0);
        cyc();
        #1; exp_ctl("t1_idle", 0, 0, 4'd0, 0, 0, 0, 0, 0, 1);
        chk_cnt("t1_after_end", 16'd1, 2'd1);

        // Test 2: SF16, bits 1 then 0, no bubble over 64 chips
        sf = SF16; bi = 1'b1; bv = 1'b1;
        #1;
        cyc();
        rdy_pulses = 0;
        for (int k = 1; k <= 64; k++) begin
            bi = (k < 32);
            bv = (k < 64);
            #1;
            ph  = (((k - 1) % 32) >= 16);
            idx = 4'((k - 1) % 16);
            if (a_rdy) rdy_pulses++;
            exp_ctl($sformatf("t2_chip%0d", k), 1, ph, idx, !ph, ph, ph && (k <= 32),
                    ((k - 1) % 32) == 0, (k % 32) == 0, (k % 32) == 0);
            cyc();
        end
        checks++;
        assert (rdy_pulses === 2) else begin
            errors++;
            $error("FAIL t2_ready_pulses observed=%0d expected=2", rdy_pulses);
        end
        bv = 1'b0;
        #1; exp_ctl("t2_idle", 0, 0, 4'd0, 0, 0, 0, 0, 0, 1);
        chk_cnt("t2_cnt", 16'd3, 2'd3);

        // Test 3: SF4, stall on REF chip 2 for 3 cycles
        sf = SF4; bi = 1'b0; bv = 1'b1;
        #1;
        cyc();
        bv = 1'b0;
        #1; exp_ctl("t3_ref0", 1, 0, 4'd0, 1, 0, 0, 1, 0, 0); cyc();
        #1; exp_ctl("t3_ref1", 1, 0, 4'd1, 1, 0, 0, 0, 0, 0); cyc();
        cr = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1; exp_ctl($sformatf("t3_stall%0d", s), 1, 0, 4'd2, 0, 0, 0, 0, 0, 0); cyc();
        end
        cr = 1'b1;
        #1; exp_ctl("t3_ref2", 1, 0, 4'd2, 1, 0, 0, 0, 0, 0); cyc();
        #1; exp_ctl("t3_ref3", 1, 0, 4'd3, 1, 0, 0, 0, 0, 0); cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_ctl($sformatf("t3_dat%0d", i), 1, 1, 4'(i), 0, 1, 0, 0, i == 3, i == 3);
            cyc();
        end
        #1; exp_ctl("t3_idle", 0, 0, 4'd0, 0, 0, 0, 0, 0, 1);
        chk_cnt("t3_cnt", 16'd4, 2'd0);

        // Test 4: sf_i changes SF8 -> SF2 during REF; next symbol uses SF2
        sf = SF8; bi = 1'b1; bv = 1'b1;
        #1;
        cyc();
        for (int k = 1; k <= 16; k++) begin
            sf = SF2;
            bi = (k < 16);
            bv = 1'b1;
            #1;
            ph = (k > 8);
            exp_ctl($sformatf("t4_sf8_chip%0d", k), 1, ph, 4'((k - 1) % 8), !ph, ph, ph,
                    k == 1, k == 16, k == 16);
            cyc();
        end
        for (int k = 1; k <= 4; k++) begin
            bv = 1'b0;
            #1;
            ph = (k > 2);
            exp_ctl($sformatf("t4_sf2_chip%0d", k), 1, ph, 4'((k - 1) % 2), !ph, ph, 1'b0,
                    k == 1, k == 4, k == 4);
            cyc();
        end
        #1; exp_ctl("t4_idle", 0, 0, 4'd0, 0, 0, 0, 0, 0, 1);
        chk_cnt("t4_cnt", 16'd6, 2'd2);

        // Test 5: async reset at DATA chip 3 of SF8
        sf = SF8; bi = 1'b1; bv = 1'b1;
        #1;
        cyc();
        bv = 1'b0;
        repeat (11) cyc();
        #1; exp_ctl("t5_dat3", 1, 1, 4'd3, 0, 1, 1, 0, 0, 0);
        rst = 1'b1;
        #1; exp_ctl("t5_in_reset", 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        chk_cnt("t5_in_reset", 16'd0, 2'd0);
        cyc();
        rst = 1'b0;
        #1; exp_ctl("t5_released", 0, 0, 4'd0, 0, 0, 0, 0, 0, 1);
        en = 1'b0;
        #1; exp_ctl("t5_en_low", 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        en = 1'b1;

        // Test 6: five SF2 symbols back-to-back, en dropped once symbol 5 starts
        sf = SF2; bi = 1'b1; bv = 1'b1;
        #1;
        cyc();
        for (int k = 1; k <= 20; k++) begin
            en = (k < 17);
            bv = 1'b1;
            #1;
            ph = (((k - 1) % 4) >= 2);
            exp_ctl($sformatf("t6_chip%0d", k), 1, ph, 4'((k - 1) % 2), !ph, ph, ph,
                    ((k - 1) % 4) == 0, (k % 4) == 0, ((k % 4) == 0) && (k < 17));
            chk_cnt($sformatf("t6_cnt%0d", k), 16'((k - 1) / 4), 2'(((k - 1) / 4) % 4));
            cyc();
        end
        #1; exp_ctl("t6_idle", 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        chk_cnt("t6_final", 16'd5, 2'd1);
        cyc();
        #1; exp_ctl("t6_stays_idle", 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
